// File: rtl/alsu_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alsu_bist_pkg
// Purpose  : Shared types and helpers for the ALSU built-in self-test engine.
//            Provides the FSM state encoding, the default LFSR seed, the bit
//            offsets of every stimulus field inside the 16-bit LFSR state,
//            the stimulus bundle type and the common LFSR/MISR feedback tap.
// Revision : 1.0 - initial release
// ============================================================================
package alsu_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Position of each ALSU stimulus field inside the LFSR state.
  localparam int A_LSB         = 0;
  localparam int B_LSB         = 3;
  localparam int OPCODE_LSB    = 6;
  localparam int CIN_BIT       = 9;
  localparam int SERIAL_IN_BIT = 10;
  localparam int RED_OP_A_BIT  = 11;
  localparam int RED_OP_B_BIT  = 12;
  localparam int BYPASS_A_BIT  = 13;
  localparam int BYPASS_B_BIT  = 14;
  localparam int DIRECTION_BIT = 15;

  typedef struct packed {
    logic       direction;
    logic       bypass_b;
    logic       bypass_a;
    logic       red_op_b;
    logic       red_op_a;
    logic       serial_in;
    logic       cin;
    logic [2:0] opcode;
    logic [2:0] b;
    logic [2:0] a;
  } stim_t;

  // Feedback for x^16 + x^14 + x^13 + x^11 + 1 (Fibonacci form).
  function automatic logic lfsr_fb(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

  // Split a raw LFSR state into the ALSU stimulus fields.
  function automatic stim_t stim_from_state(input logic [15:0] s);
    stim_t v;
    v.a         = s[A_LSB +: 3];
    v.b         = s[B_LSB +: 3];
    v.opcode    = s[OPCODE_LSB +: 3];
    v.cin       = s[CIN_BIT];
    v.serial_in = s[SERIAL_IN_BIT];
    v.red_op_a  = s[RED_OP_A_BIT];
    v.red_op_b  = s[RED_OP_B_BIT];
    v.bypass_a  = s[BYPASS_A_BIT];
    v.bypass_b  = s[BYPASS_B_BIT];
    v.direction = s[DIRECTION_BIT];
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : alsu_bist_if
// Purpose  : Connection bundle between the self-test engine and the ALSU.
//            master : self-test side (drives reset + stimulus, reads response)
//            slave  : ALSU side (reads reset + stimulus, drives response)
// Signals  : alsu_rst, A, B, opcode, cin, serial_in, red_op_A, red_op_B,
//            bypass_A, bypass_B, direction  -> towards the ALSU
//            alsu_out[5:0], alsu_leds[15:0] -> from the ALSU
// Revision : 1.0 - initial release
// ============================================================================
interface alsu_bist_if;
  logic        alsu_rst;
  logic [2:0]  A;
  logic [2:0]  B;
  logic [2:0]  opcode;
  logic        cin;
  logic        serial_in;
  logic        red_op_A;
  logic        red_op_B;
  logic        bypass_A;
  logic        bypass_B;
  logic        direction;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;

  modport master (
    output alsu_rst, A, B, opcode, cin, serial_in, red_op_A, red_op_B,
           bypass_A, bypass_B, direction,
    input  alsu_out, alsu_leds
  );

  modport slave (
    input  alsu_rst, A, B, opcode, cin, serial_in, red_op_A, red_op_B,
           bypass_A, bypass_B, direction,
    output alsu_out, alsu_leds
  );
endinterface
`default_nettype wire

// File: rtl/alsu_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : alsu_bist_lfsr
// Purpose  : 16-bit Fibonacci shift register (x^16+x^14+x^13+x^11+1) usable
//            both as a pattern generator (data_in = 0) and as a multiple-input
//            signature register (data_in = response word).
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous active-low reset, loads RESET_VAL
//            en       - advance one step: q <= {q[14:0], fb(q)} ^ data_in
//            load     - synchronous load of load_val (wins over en)
//            load_val - value loaded when load is high
//            data_in  - word XORed into the shifted state
//            q        - current register state
// Revision : 1.0 - initial release
// ============================================================================
module alsu_bist_lfsr
  import alsu_bist_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [15:0] data_in,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= {q[14:0], lfsr_fb(q)} ^ data_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alsu_bist.sv
`default_nettype none
// ============================================================================
// Module   : alsu_bist
// Purpose  : Built-in self-test engine for the ALSU. Applies N_VEC
//            pseudo-random vectors, compacts the ALSU out/leds responses into
//            a 16-bit MISR and compares the final signature with GOLDEN.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-low reset
//            start     - one-cycle run request (accepted in IDLE/DONE only)
//            busy      - high while clearing, running or draining
//            done      - high once the run has finished, until next start
//            pass      - signature == GOLDEN, valid while done
//            signature - MISR state
//            alsu      - master side of alsu_bist_if (reset, stimulus,
//                        response)
// Config   : ALSU_BIST_INVALID_EN - when defined, raw LFSR fields are driven
//            (opcodes 6/7 and reduction with opcode >= 2 included); otherwise
//            only legal ALSU combinations are generated.
// Revision : 1.0 - initial release
// ============================================================================
module alsu_bist
  import alsu_bist_pkg::*;
#(
  parameter int unsigned N_VEC  = 64,
  parameter int unsigned LAT    = 2,
  parameter logic [15:0] SEED   = DEFAULT_SEED,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  alsu_bist_if.master alsu
);

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
  localparam logic [15:0] LAST_VEC   = 16'(N_VEC - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(LAT - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;

  logic        clear;
  logic        vec_en;
  logic        busy_next;
  logic        done_next;
  logic        pass_capture;

  logic [15:0] stim_state;
  stim_t       stim_raw;
  stim_t       stim_next;
  stim_t       stim_q;
  logic        alsu_rst_q;

  logic [LAT-1:0] vld;
  logic [15:0]    misr_in;
  logic [5:0]     leds_unused;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Cycle counter for RUN and DRAIN; restarts at every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (next_state != state) begin
      cnt <= 16'd0;
    end else if (state == RUN || state == DRAIN) begin
      cnt <= cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLR;
      CLR:     next_state = RUN;
      RUN:     if (cnt == LAST_VEC) next_state = DRAIN;
      DRAIN:   if (cnt == LAST_DRAIN) next_state = DONE;
      DONE:    if (start) next_state = CLR;
      default: next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode. All block outputs are registered from these, so
  // decoding the next state makes each output line up with its state.
  // --------------------------------------------------------------------------
  always_comb begin
    clear        = 1'b0;
    vec_en       = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    pass_capture = 1'b0;
    case (next_state)
      CLR: begin
        clear     = 1'b1;
        busy_next = 1'b1;
      end
      RUN: begin
        vec_en    = 1'b1;
        busy_next = 1'b1;
      end
      DRAIN: begin
        busy_next = 1'b1;
      end
      DONE: begin
        done_next    = 1'b1;
        pass_capture = (state == DRAIN);
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stimulus generator: the current LFSR state is the vector about to be
  // presented; the LFSR steps as that vector is registered.
  // --------------------------------------------------------------------------
  alsu_bist_lfsr #(
    .RESET_VAL (SEED_EFF)
  ) u_stim_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (vec_en),
    .load     (clear),
    .load_val (SEED_EFF),
    .data_in  (16'h0000),
    .q        (stim_state)
  );

  assign stim_raw = stim_from_state(stim_state);

  always_comb begin
    stim_next = stim_raw;
`ifdef ALSU_BIST_INVALID_EN
    // Raw fields pass through so the ALSU invalid-combination path is hit.
`else
    // Fold opcodes 6/7 onto 2/3 and drop reduction for non-logic opcodes.
    if (stim_raw.opcode[2:1] == 2'b11) begin
      stim_next.opcode = stim_raw.opcode & 3'b011;
    end
    if (stim_next.opcode >= 3'd2) begin
      stim_next.red_op_a = 1'b0;
      stim_next.red_op_b = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stim_q     <= '0;
      alsu_rst_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      stim_q     <= vec_en ? stim_next : '0;
      alsu_rst_q <= clear;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // pass is sampled once on DONE entry; the MISR is idle from then on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass <= 1'b0;
    end else if (pass_capture) begin
      pass <= (signature == GOLDEN);
    end else if (!done_next) begin
      pass <= 1'b0;
    end
  end

  assign alsu.alsu_rst  = alsu_rst_q;
  assign alsu.A         = stim_q.a;
  assign alsu.B         = stim_q.b;
  assign alsu.opcode    = stim_q.opcode;
  assign alsu.cin       = stim_q.cin;
  assign alsu.serial_in = stim_q.serial_in;
  assign alsu.red_op_A  = stim_q.red_op_a;
  assign alsu.red_op_B  = stim_q.red_op_b;
  assign alsu.bypass_A  = stim_q.bypass_a;
  assign alsu.bypass_B  = stim_q.bypass_b;
  assign alsu.direction = stim_q.direction;

  // --------------------------------------------------------------------------
  // Compaction window: vld[0] mirrors "a vector is on the bus this cycle",
  // so the tap LAT-1 stages later marks the cycle whose ALSU response
  // belongs to that vector. Exactly N_VEC taps are set per run.
  // --------------------------------------------------------------------------
  generate
    if (LAT == 1) begin : g_vld_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= '0;
        end else begin
          vld <= vec_en;
        end
      end
    end else begin : g_vld_chain
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= '0;
        end else begin
          vld <= {vld[LAT-2:0], vec_en};
        end
      end
    end
  endgenerate

  // Only the low ten leds bits fit beside the 6-bit out word.
  assign misr_in     = {alsu.alsu_leds[9:0], alsu.alsu_out};
  assign leds_unused = alsu.alsu_leds[15:10];

  alsu_bist_lfsr #(
    .RESET_VAL (16'h0000)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .en       (vld[LAT-1]),
    .load     (clear),
    .load_val (16'h0000),
    .data_in  (misr_in),
    .q        (signature)
  );

endmodule
`default_nettype wire

// File: tb/tb_alsu_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_alsu_bist
// Purpose  : Directed self-checking bench for alsu_bist. Three instances:
//            u_one (N_VEC=1, SEED=1, zero ALSU response), u_two (N_VEC=2,
//            LAT=1, SEED=1, constant response) and u_def (defaults, driven
//            by a registered ALSU stand-in whose response is a fixed
//            function of the stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alsu_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_def, start_one, start_two;

  logic        busy_def, done_def, pass_def;
  logic [15:0] sig_def;
  logic        busy_one, done_one, pass_one;
  logic [15:0] sig_one;
  logic        busy_two, done_two, pass_two;
  logic [15:0] sig_two;

  int n_run  = 0;
  int n_fail = 0;
  int rst_pulses = 0;

  alsu_bist_if def_if ();
  alsu_bist_if one_if ();
  alsu_bist_if two_if ();

  alsu_bist #(.N_VEC(64), .LAT(2), .SEED(16'hACE1), .GOLDEN(16'h0000)) u_def (
    .clk(clk), .rst(rst_n), .start(start_def), .busy(busy_def), .done(done_def),
    .pass(pass_def), .signature(sig_def), .alsu(def_if));

  alsu_bist #(.N_VEC(1), .LAT(2), .SEED(16'h0001), .GOLDEN(16'h0000)) u_one (
    .clk(clk), .rst(rst_n), .start(start_one), .busy(busy_one), .done(done_one),
    .pass(pass_one), .signature(sig_one), .alsu(one_if));

  alsu_bist #(.N_VEC(2), .LAT(1), .SEED(16'h0001), .GOLDEN(16'h0063)) u_two (
    .clk(clk), .rst(rst_n), .start(start_two), .busy(busy_two), .done(done_two),
    .pass(pass_two), .signature(sig_two), .alsu(two_if));

  // Stimulus packed in LFSR bit order.
  logic [15:0] def_stim, one_stim, two_stim;
  assign def_stim = {def_if.direction, def_if.bypass_B, def_if.bypass_A, def_if.red_op_B,
                     def_if.red_op_A, def_if.serial_in, def_if.cin, def_if.opcode,
                     def_if.B, def_if.A};
  assign one_stim = {one_if.direction, one_if.bypass_B, one_if.bypass_A, one_if.red_op_B,
                     one_if.red_op_A, one_if.serial_in, one_if.cin, one_if.opcode,
                     one_if.B, one_if.A};
  assign two_stim = {two_if.direction, two_if.bypass_B, two_if.bypass_A, two_if.red_op_B,
                     two_if.red_op_A, two_if.serial_in, two_if.cin, two_if.opcode,
                     two_if.B, two_if.A};

  assign one_if.alsu_out  = 6'h00;
  assign one_if.alsu_leds = 16'h0000;
  assign two_if.alsu_out  = 6'h21;
  assign two_if.alsu_leds = 16'h0000;

  function automatic logic [5:0] resp_out(input logic [15:0] v);
    return {v[2:0], v[5:3] ^ v[8:6]};
  endfunction

  function automatic logic [15:0] resp_leds(input logic [15:0] v);
    return {6'b0, v[11], v[12], v[13], v[14], v[9], v[10], v[15], v[8:6]};
  endfunction

  // ALSU stand-in: one register stage, so its response for the vector on the
  // bus is visible in the following cycle (LAT = 2 alignment).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      def_if.alsu_out  <= 6'h00;
      def_if.alsu_leds <= 16'h0000;
    end else begin
      def_if.alsu_out  <= resp_out(def_stim);
      def_if.alsu_leds <= resp_leds(def_stim);
    end
  end

  always @(posedge clk) begin
    if (def_if.alsu_rst) rst_pulses <= rst_pulses + 1;
  end

  // Reference model of the default run.
  logic [15:0] exp_vec [64];
  logic [15:0] exp_sig;

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] legal(input logic [15:0] s);
    logic [15:0] v;
    v = s;
`ifndef ALSU_BIST_INVALID_EN
    if (v[8:7] == 2'b11) v[8] = 1'b0;
    if (v[8:6] >= 3'd2) begin
      v[11] = 1'b0;
      v[12] = 1'b0;
    end
`endif
    return v;
  endfunction

  task automatic build_model;
    logic [15:0] s, m, v, l;
    s = 16'hACE1;
    m = 16'h0000;
    for (int k = 0; k < 64; k++) begin
      v = legal(s);
      exp_vec[k] = v;
      l = resp_leds(v);
      m = nxt(m) ^ {l[9:0], resp_out(v)};
      s = nxt(s);
    end
    exp_sig = m;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_def(input int mid_start_k);
    int p0;
    int op67;
    op67 = 0;
    @(negedge clk); start_def = 1'b1;
    @(negedge clk); start_def = 1'b0;
    p0 = rst_pulses;
    chk("def_clr_alsu_rst", def_if.alsu_rst, 1);
    chk("def_clr_busy", busy_def, 1);
    chk("def_clr_done", done_def, 0);
    chk("def_clr_sig", sig_def, 0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      start_def = (k == mid_start_k);
      chk("def_vec", def_stim, exp_vec[k]);
      chk("def_run_busy", busy_def, 1);
      chk("def_run_alsu_rst", def_if.alsu_rst, 0);
      if (def_stim[8:6] >= 3'd6) op67++;
`ifndef ALSU_BIST_INVALID_EN
      chk("def_opcode_legal", def_stim[8:6] <= 3'd5, 1);
`endif
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start_def = 1'b0;
      chk("def_drain_stim", def_stim, 0);
      chk("def_drain_busy", busy_def, 1);
      chk("def_drain_done", done_def, 0);
    end
    @(negedge clk);
    chk("def_done", done_def, 1);
    chk("def_done_busy", busy_def, 0);
    chk("def_sig", sig_def, exp_sig);
    chk("def_pass", pass_def, exp_sig == 16'h0000);
    chk("def_rst_pulses", rst_pulses - p0, 1);
`ifdef ALSU_BIST_INVALID_EN
    chk("def_op67_seen", op67 > 0, 1);
`endif
    repeat (3) @(negedge clk);
    chk("def_done_hold", done_def, 1);
    chk("def_sig_frozen", sig_def, exp_sig);
  endtask

  initial begin
    rst_n     = 1'b0;
    start_def = 1'b0;
    start_one = 1'b0;
    start_two = 1'b0;
    build_model();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", busy_def, 0);
    chk("rst_done", done_def, 0);
    chk("rst_pass", pass_def, 0);
    chk("rst_sig", sig_def, 0);
    chk("rst_alsu_rst", def_if.alsu_rst, 0);
    chk("rst_stim", def_stim, 0);
    chk("rst_one_sig", sig_one, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N_VEC=1, SEED=1, zero response: A=1, B=0, opcode=0, done at E0+4
    start_one = 1'b1;
    @(negedge clk); start_one = 1'b0;
    chk("one_clr_alsu_rst", one_if.alsu_rst, 1);
    @(negedge clk);
    chk("one_vec0", one_stim[8:0], 9'h001);
    chk("one_vec0_busy", busy_one, 1);
    @(negedge clk);
    chk("one_drain0_done", done_one, 0);
    chk("one_drain0_stim", one_stim, 0);
    @(negedge clk);
    chk("one_drain1_done", done_one, 0);
    @(negedge clk);
    chk("one_done", done_one, 1);
    chk("one_busy_low", busy_one, 0);
    chk("one_sig", sig_one, 16'h0000);
    chk("one_pass", pass_one, 1);

    // N_VEC=2, LAT=1, constant out=0x21: vectors A=1 then A=2, sig 0x0063
    @(negedge clk); start_two = 1'b1;
    @(negedge clk); start_two = 1'b0;
    chk("two_clr_alsu_rst", two_if.alsu_rst, 1);
    @(negedge clk);
    chk("two_vec0", two_stim, 16'h0001);
    @(negedge clk);
    chk("two_vec1", two_stim, 16'h0002);
    @(negedge clk);
    chk("two_drain_busy", busy_two, 1);
    chk("two_drain_done", done_two, 0);
    @(negedge clk);
    chk("two_done", done_two, 1);
    chk("two_sig", sig_two, 16'h0063);
    chk("two_pass", pass_two, 1);

    // Default runs: plain, repeat from DONE, start pulsed mid-RUN
    run_def(-1);
    run_def(-1);
    run_def(10);

    // Reset asserted on vector 30, then a fresh run
    @(negedge clk); start_def = 1'b1;
    @(negedge clk); start_def = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      chk("rstrun_vec", def_stim, exp_vec[k]);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_stim", def_stim, 0);
    chk("midrst_busy", busy_def, 0);
    chk("midrst_done", done_def, 0);
    chk("midrst_sig", sig_def, 0);
    chk("midrst_alsu_rst", def_if.alsu_rst, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_busy", busy_def, 0);
    run_def(-1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
